// File: rtl/calc_inv_arbiter.sv
// rtl/calc_inv_arbiter.sv - round-robin arbiter sharing one calc_inv engine between requesters
// Optional engine watchdog: CALC_INV_ARB_TIMEOUT_EN (limit set by TIMEOUT).
module calc_inv_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = 128,
   parameter  int TIMEOUT = 64,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [ID_W-1:0]           resp_id,
   output logic [DATA_W-1:0]         resp_data,
   output logic                      resp_err,
   output logic                      eng_en,
   output logic [DATA_W-1:0]         eng_data,
   input  logic [DATA_W-1:0]         eng_result,
   input  logic                      eng_done,
   output logic                      busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ID_W-1:0]     r_ptr;
   logic [ID_W-1:0]     r_resp_id;
   logic [DATA_W-1:0]   r_eng_data;
   logic [DATA_W-1:0]   r_resp_data;
   logic                r_first;

   logic                w_found;
   logic [ID_W-1:0]     w_gnt_id;
   logic [NUM_REQ-1:0]  w_gnt;
   logic [ID_W-1:0]     w_ptr_nxt;
   logic                w_done_smp;
   logic                w_timeout;
   int unsigned         w_idx;

   // Search from the pointer upward with wrap; first valid requester wins.
   always_comb begin
      w_found  = 1'b0;
      w_gnt_id = '0;
      w_gnt    = '0;
      w_idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = (int'(r_ptr) + k) % NUM_REQ;
         if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
            w_found  = 1'b1;
            w_gnt_id = w_idx[ID_W-1:0];
         end
      end
      if (w_found) w_gnt[w_gnt_id] = 1'b1;
   end

   assign w_ptr_nxt  = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
   // First ISSUE cycle may still see done left over from the previous op.
   assign w_done_smp = (r_state == S_ISSUE) && !r_first && eng_done;

`ifdef CALC_INV_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] r_cnt;
   logic             r_resp_err;

   assign w_timeout = (r_state == S_ISSUE) && !w_done_smp && (r_cnt == CNT_W'(TIMEOUT - 1));
   assign resp_err  = r_resp_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_resp_err <= 1'b0;
      end else if (r_state == S_IDLE) begin
         r_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
         if (w_done_smp) begin
            r_resp_err <= 1'b0;
         end else if (w_timeout) begin
            r_resp_err <= 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end
`else
   assign w_timeout = 1'b0;
   assign resp_err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_found)                  w_state_nxt = S_ISSUE;
         S_ISSUE: if (w_done_smp || w_timeout)  w_state_nxt = S_RESP;
         S_RESP:  if (resp_ready)               w_state_nxt = S_IDLE;
         default:                               w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_resp_id   <= '0;
         r_eng_data  <= '0;
         r_resp_data <= '0;
         r_first     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_eng_data <= req_data[w_gnt_id*DATA_W +: DATA_W];
                  r_resp_id  <= w_gnt_id;
                  r_ptr      <= w_ptr_nxt;
                  r_first    <= 1'b1;
               end
            end
            S_ISSUE: begin
               r_first <= 1'b0;
               if (w_done_smp)     r_resp_data <= eng_result;
               else if (w_timeout) r_resp_data <= '0;
            end
            default: ;
         endcase
      end
   end

   assign req_ready  = (r_state == S_IDLE && !rst) ? w_gnt : '0;
   assign eng_en     = (r_state == S_ISSUE);
   assign eng_data   = r_eng_data;
   assign resp_valid = (r_state == S_RESP);
   assign resp_id    = r_resp_id;
   assign resp_data  = r_resp_data;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_calc_inv_arbiter.sv
// tb/tb_calc_inv_arbiter.sv - directed self-checking bench for calc_inv_arbiter
module tb_calc_inv_arbiter;

   localparam int NR = 4;
   localparam int DW = 128;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              resp_valid;
   logic              resp_ready;
   logic [1:0]        resp_id;
   logic [DW-1:0]     resp_data;
   logic              resp_err;
   logic              eng_en;
   logic [DW-1:0]     eng_data;
   logic [DW-1:0]     eng_result;
   logic              eng_done;
   logic              busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Engine model: 0 = done one cycle after en, 1 = done stuck high, 2 = never done.
   int   done_mode;
   logic r_done_q;

   always #5 clk = ~clk;

   always_ff @(posedge clk) r_done_q <= eng_en;

   assign eng_result = ~eng_data;
   assign eng_done   = (done_mode == 0) ? r_done_q : (done_mode == 1);

   calc_inv_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .eng_en     (eng_en),
      .eng_data   (eng_data),
      .eng_result (eng_result),
      .eng_done   (eng_done),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_resp(input string tag);
      int c = 0;
      while (resp_valid !== 1'b1 && c < 30) begin
         step();
         c++;
      end
      chk(tag, {127'd0, resp_valid}, 128'd1);
   endtask

   task automatic wait_grant(input string tag);
      int c = 0;
      while (req_ready === '0 && c < 30) begin
         step();
         c++;
      end
      chk(tag, {124'd0, (req_ready !== '0)}, 128'd1);
   endtask

   logic [DW-1:0] d_rr  [NR];
   logic [DW-1:0] e_rr  [NR];
   int            order [5];

   initial begin
      d_rr[0] = 128'h0;
      e_rr[0] = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
      d_rr[1] = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
      e_rr[1] = 128'h0;
      d_rr[2] = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
      e_rr[2] = 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;
      d_rr[3] = 128'h0F0F0F0F123456780F0F0F0F12345678;
      e_rr[3] = 128'hF0F0F0F0EDCBA987F0F0F0F0EDCBA987;
      order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

      done_mode  = 0;
      rst        = 1'b1;
      req_valid  = '0;
      req_data   = '0;
      resp_ready = 1'b0;
      step();
      step();
      chk("rst_req_ready",  {124'd0, req_ready}, 128'd0);
      chk("rst_eng_en",     {127'd0, eng_en}, 128'd0);
      chk("rst_resp_valid", {127'd0, resp_valid}, 128'd0);
      chk("rst_busy",       {127'd0, busy}, 128'd0);
      chk("rst_eng_data",   eng_data, 128'd0);
      chk("rst_resp_data",  resp_data, 128'd0);
      chk("rst_resp_id",    {126'd0, resp_id}, 128'd0);
      chk("rst_resp_err",   {127'd0, resp_err}, 128'd0);

      // Single request from requester 2
      @(negedge clk);
      rst = 1'b0;
      req_valid = 4'b0100;
      req_data[2*DW +: DW] = 128'hFFFFFFFFFFFFFFFF0000000000000000;
      #1;
      chk("single_req_ready", {124'd0, req_ready}, 128'h4);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("single_issue_en",    {127'd0, eng_en}, 128'd1);
      chk("single_issue_rdy",   {124'd0, req_ready}, 128'd0);
      chk("single_issue_data",  eng_data, 128'hFFFFFFFFFFFFFFFF0000000000000000);
      chk("single_issue_busy",  {127'd0, busy}, 128'd1);
      step();
      chk("single_issue2_en",   {127'd0, eng_en}, 128'd1);
      chk("single_issue2_rv",   {127'd0, resp_valid}, 128'd0);
      step();
      chk("single_resp_valid",  {127'd0, resp_valid}, 128'd1);
      chk("single_resp_id",     {126'd0, resp_id}, 128'd2);
      chk("single_resp_data",   resp_data, 128'h0000000000000000FFFFFFFFFFFFFFFF);
      chk("single_resp_err",    {127'd0, resp_err}, 128'd0);
      chk("single_resp_en",     {127'd0, eng_en}, 128'd0);
      resp_ready = 1'b1;
      step();
      chk("single_done_rv",     {127'd0, resp_valid}, 128'd0);
      chk("single_done_busy",   {127'd0, busy}, 128'd0);

      // Round robin from pointer 0 with all four requesting
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = d_rr[i];
      req_valid = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         #0;
         wait_grant($sformatf("rr%0d_grant_seen", n));
         chk($sformatf("rr%0d_grant", n), {124'd0, req_ready}, 128'd1 << order[n]);
         wait_resp($sformatf("rr%0d_resp_seen", n));
         chk($sformatf("rr%0d_id", n),   {126'd0, resp_id}, 128'(order[n]));
         chk($sformatf("rr%0d_data", n), resp_data, e_rr[order[n]]);
         step();
      end
      req_valid = '0;
      step();

      // Backpressure: pointer is 1, so only requester 0 gets granted first
      resp_ready = 1'b0;
      req_valid  = 4'b0001;
      #1;
      chk("bp_grant0", {124'd0, req_ready}, 128'h1);
      step();
      req_valid = 4'b0010;
      wait_resp("bp_resp_seen");
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_hold%0d_rv", c),   {127'd0, resp_valid}, 128'd1);
         chk($sformatf("bp_hold%0d_id", c),   {126'd0, resp_id}, 128'd0);
         chk($sformatf("bp_hold%0d_data", c), resp_data, e_rr[0]);
         chk($sformatf("bp_hold%0d_en", c),   {127'd0, eng_en}, 128'd0);
         chk($sformatf("bp_hold%0d_rdy", c),  {124'd0, req_ready}, 128'd0);
         step();
      end
      resp_ready = 1'b1;
      step();
      chk("bp_after_rv",    {127'd0, resp_valid}, 128'd0);
      chk("bp_after_grant", {124'd0, req_ready}, 128'h2);
      step();
      req_valid = '0;
      wait_resp("bp_next_seen");
      chk("bp_next_id",   {126'd0, resp_id}, 128'd1);
      chk("bp_next_data", resp_data, e_rr[1]);
      step();

      // Stale done: engine done stuck high; pointer 2, requester 3 granted
      done_mode = 1;
      req_data[3*DW +: DW] = 128'h00000000000000000000000012345678;
      req_valid = 4'b1000;
      #1;
      chk("stale_grant", {124'd0, req_ready}, 128'h8);
      step();
      req_valid = '0;
      #1;
      chk("stale_issue1_en", {127'd0, eng_en}, 128'd1);
      chk("stale_issue1_rv", {127'd0, resp_valid}, 128'd0);
      step();
      chk("stale_issue2_en", {127'd0, eng_en}, 128'd1);
      chk("stale_issue2_rv", {127'd0, resp_valid}, 128'd0);
      step();
      chk("stale_resp_rv",   {127'd0, resp_valid}, 128'd1);
      chk("stale_resp_id",   {126'd0, resp_id}, 128'd3);
      chk("stale_resp_data", resp_data, 128'hFFFFFFFFFFFFFFFFFFFFFFFFEDCBA987);
      step();

      // Mid-op reset: requester 1 granted (pointer 0), reset during ISSUE
      done_mode = 2;
      req_valid = 4'b0010;
      #1;
      chk("mid_grant", {124'd0, req_ready}, 128'h2);
      step();
      req_valid = '0;
      #1;
      chk("mid_issue_en", {127'd0, eng_en}, 128'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_rdy", {124'd0, req_ready}, 128'd0);
      step();
      rst = 1'b0;
      #1;
      chk("mid_after_en",   {127'd0, eng_en}, 128'd0);
      chk("mid_after_rv",   {127'd0, resp_valid}, 128'd0);
      chk("mid_after_busy", {127'd0, busy}, 128'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("mid_no_resp%0d", c), {127'd0, resp_valid}, 128'd0);
      end
      done_mode = 0;
      req_valid = 4'b1111;
      #1;
      chk("mid_ptr0_grant", {124'd0, req_ready}, 128'h1);
      step();
      req_valid = '0;
      wait_resp("mid_next_seen");
      chk("mid_next_id",   {126'd0, resp_id}, 128'd0);
      chk("mid_next_data", resp_data, e_rr[0]);
      step();

`ifdef CALC_INV_ARB_TIMEOUT_EN
      // Watchdog: pointer 1, requester 2 granted, engine silent
      done_mode = 2;
      req_valid = 4'b0100;
      #1;
      chk("to_grant", {124'd0, req_ready}, 128'h4);
      step();
      req_valid = '0;
      for (int c = 0; c < 8; c++) begin
         #0;
         chk($sformatf("to_issue%0d_en", c), {127'd0, eng_en}, 128'd1);
         chk($sformatf("to_issue%0d_rv", c), {127'd0, resp_valid}, 128'd0);
         step();
      end
      chk("to_resp_rv",   {127'd0, resp_valid}, 128'd1);
      chk("to_resp_err",  {127'd0, resp_err}, 128'd1);
      chk("to_resp_data", resp_data, 128'd0);
      chk("to_resp_id",   {126'd0, resp_id}, 128'd2);
      chk("to_resp_en",   {127'd0, eng_en}, 128'd0);
      step();
      done_mode = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
